// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId plus flush
// generation for interrupts and exceptions detected in the M stage.
module cp0_exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_M,
    input  logic        valid_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        WE,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        EXLClr,
    output logic        EXC_flush,
    output logic [31:0] EPC_out,
    output logic [31:0] DOut
);

    localparam logic [31:0] PRID = 32'h2017_1207;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] pc_adj;
    logic [31:0] sr_w;
    logic [31:0] cause_w;

    assign int_req   = (|(HWInt & im_q)) & ie_q & ~exl_q & valid_M;
    assign exc_req   = (ExcCode_M != 5'd0) & ~exl_q & valid_M;
    assign EXC_flush = int_req | exc_req;

    // A delay-slot victim restarts at its branch so the branch re-executes.
    assign pc_adj = BD_M ? (PC_M - 32'd4) : PC_M;

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
        if (EXC_flush) begin
            exl_d = 1'b1;
            bd_d  = BD_M;
            epc_d = pc_adj & 32'hFFFF_FFFC;
            exc_d = int_req ? 5'd0 : ExcCode_M;
        end else begin
            if (WE && A2 == 5'd12) begin
                im_d  = DIn[15:10];
                exl_d = DIn[1];
                ie_d  = DIn[0];
            end
            if (WE && A2 == 5'd14) begin
                epc_d = DIn & 32'hFFFF_FFFC;
            end
            // eret wins over an mtc0 that would set EXL in the same cycle
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    assign sr_w    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_w = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
    assign EPC_out = epc_q;

    always_comb begin
        DOut = 32'd0;
        case (A1)
            5'd12:   DOut = sr_w;
            5'd13:   DOut = cause_w;
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID;
            default: DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: word-level reference model of the
// CP0 registers, directed scenarios followed by random traffic.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_M;
    logic        valid_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic        WE;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        EXLClr;
    logic        EXC_flush;
    logic [31:0] EPC_out;
    logic [31:0] DOut;

    cp0_exc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .PC_M      (PC_M),
        .valid_M   (valid_M),
        .BD_M      (BD_M),
        .ExcCode_M (ExcCode_M),
        .HWInt     (HWInt),
        .WE        (WE),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .EXLClr    (EXLClr),
        .EXC_flush (EXC_flush),
        .EPC_out   (EPC_out),
        .DOut      (DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        int          tag;
        bit          flush;
        logic [31:0] epc;
        logic [31:0] dout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;

    // Reference state kept as plain architectural words.
    logic [31:0] m_sr = 0;
    logic [31:0] m_cause = 0;
    logic [31:0] m_epc = 0;

    task automatic drive(input bit rst, input bit chk,
                         input logic [31:0] pc, input bit v,
                         input bit bd, input logic [4:0] ec,
                         input logic [5:0] hw, input bit we,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] din, input bit clr);
        exp_t e;
        bit   ie, exl, intr, excr, fl;
        int   im;
        @(posedge clk);
        #1;
        reset = rst; PC_M = pc; valid_M = v; BD_M = bd;
        ExcCode_M = ec; HWInt = hw; WE = we; A1 = a1; A2 = a2;
        DIn = din; EXLClr = clr;
        im   = int'((m_sr >> 10) % 64);
        ie   = m_sr[0];
        exl  = m_sr[1];
        intr = v && ie && !exl && ((im & int'(hw)) != 0);
        excr = v && !exl && (ec != 0);
        fl   = intr || excr;
        e.chk   = chk;
        e.tag   = tag;
        e.flush = fl;
        e.epc   = m_epc;
        case (a1)
            5'd12:   e.dout = m_sr;
            5'd13:   e.dout = m_cause;
            5'd14:   e.dout = m_epc;
            5'd15:   e.dout = 32'h2017_1207;
            default: e.dout = 32'd0;
        endcase
        exp_q.push_back(e);
        tag++;
        if (rst) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            m_cause = (m_cause & ~(32'd63 << 10)) | (32'(hw) << 10);
            if (fl) begin
                m_sr = m_sr | 32'd2;
                m_epc = (bd ? pc - 4 : pc) & ~32'd3;
                m_cause = (m_cause & ~(32'd1 << 31) & ~(32'd31 << 2))
                        | (32'(bd) << 31)
                        | (32'(intr ? 5'd0 : ec) << 2);
            end else begin
                if (we && a2 == 12) m_sr = din & 32'h0000_FC03;
                if (we && a2 == 14) m_epc = din & ~32'd3;
                if (clr) m_sr = m_sr & ~32'd2;
            end
        end
    endtask

    task automatic idle(input logic [4:0] a1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, a1, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                checks++;
                if (EXC_flush !== e.flush) begin
                    errors++;
                    $display("FAIL flush #%0d got %0b want %0b",
                             e.tag, EXC_flush, e.flush);
                end
                checks++;
                if (EPC_out !== e.epc) begin
                    errors++;
                    $display("FAIL epc_out #%0d got %h want %h",
                             e.tag, EPC_out, e.epc);
                end
                checks++;
                if (DOut !== e.dout) begin
                    errors++;
                    $display("FAIL dout #%0d A1=%0d got %h want %h",
                             e.tag, A1, DOut, e.dout);
                end
            end
        end
    end

    initial begin
        logic [4:0] sel;
        reset = 1; PC_M = 0; valid_M = 0; BD_M = 0; ExcCode_M = 0;
        HWInt = 0; WE = 0; A1 = 0; A2 = 0; DIn = 0; EXLClr = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0);
        // Interrupt taken, EPC = PC
        drive(0, 1, 0, 0, 0, 0, 0, 1, 12, 12, 32'h0000_FC01, 0);
        drive(0, 1, 32'h3008, 1, 0, 0, 6'b000001, 0, 12, 0, 0, 0);
        idle(14);
        idle(13);
        idle(12);
        // Delay-slot exception
        drive(0, 1, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1);
        drive(0, 1, 32'h3010, 1, 1, 5'd4, 0, 0, 13, 0, 0, 0);
        idle(13);
        idle(14);
        // Nothing taken under EXL; eret re-opens
        drive(0, 1, 32'h3020, 1, 0, 5'd10, 6'h3F, 0, 12, 0, 0, 0);
        drive(0, 1, 32'h3024, 1, 0, 5'd10, 6'h3F, 0, 12, 0, 0, 1);
        drive(0, 1, 32'h3028, 1, 0, 5'd10, 6'h3F, 0, 13, 0, 0, 0);
        idle(13);
        // Interrupt beats exception and a same-cycle mtc0 EPC
        drive(0, 1, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1);
        drive(0, 1, 32'h4000, 1, 0, 5'd12, 6'b000100, 1, 14, 14,
              32'hDEAD_BEEF, 0);
        idle(14);
        idle(13);
        // PRId, Cause read-only, EPC low bits masked
        idle(15);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 13, 13, 32'hFFFF_FFFF, 0);
        idle(13);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 14, 14, 32'h0000_3007, 0);
        idle(14);
        // eret plus mtc0 SR with EXL=1 in DIn: EXL ends 0
        drive(0, 1, 0, 0, 0, 0, 0, 1, 12, 12, 32'h0000_FC03, 1);
        idle(12);
        // Bubbles hold off a pending interrupt
        for (int i = 0; i < 3; i++)
            drive(0, 1, 32'h5000, 0, 0, 0, 6'b000001, 0, 12, 0, 0, 0);
        drive(0, 1, 32'h5004, 1, 0, 0, 6'b000001, 0, 12, 0, 0, 0);
        // Reset mid-EXL, with competing updates
        drive(1, 1, 32'h5008, 1, 0, 5'd3, 6'h3F, 1, 12, 14,
              32'h1234_5678, 1);
        idle(12);
        idle(14);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            sel = 5'(12 + $urandom_range(0, 3));
            drive(($urandom_range(0, 99) < 2),
                  1,
                  $urandom,
                  ($urandom_range(0, 99) < 70),
                  1'($urandom),
                  ($urandom_range(0, 99) < 60) ? 5'd0 : 5'($urandom),
                  6'($urandom),
                  ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : sel,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom)
                      : 5'(12 + $urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0) ? 32'h0000_FC01 ^ 32'($urandom_range(0, 3))
                      : $urandom,
                  ($urandom_range(0, 99) < 20));
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
